// File: rtl/tcdm_interconnect_pkg.sv
// Shared types for the TCDM interconnect: bank arbitration mode and
// the response-tracking tag carried through the bank read pipe.
package tcdm_interconnect_pkg;

   typedef enum logic [1:0] {
      CORE_PRIO   = 2'd0,
      ROUND_ROBIN = 2'd1,
      EXT_PRIO    = 2'd2
   } arb_mode_e;

   typedef struct packed {
      logic vld;
      logic owner;
      logic wen;
   } resp_tag_t;

endpackage

// File: rtl/tcdm_bank_resp_pipe.sv
// Response tag shift register matching the bank read latency; the last
// stage raises vld_o for the port that owned the access.
module tcdm_bank_resp_pipe
   import tcdm_interconnect_pkg::*;
#(
   parameter int RespLat     = 1,
   parameter bit WriteRespOn = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [2:0] tag_i,
   output logic [1:0] vld_o
);

   resp_tag_t                tag;
   resp_tag_t [RespLat-1:0] pipe_q;
   resp_tag_t [RespLat-1:0] pipe_d;
   resp_tag_t                last;

   assign tag = resp_tag_t'(tag_i);

   if (RespLat == 1) begin : g_one
      assign pipe_d = tag;
   end else begin : g_many
      assign pipe_d = {pipe_q[RespLat-2:0], tag};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign last = pipe_q[RespLat-1];

   always_comb begin
      vld_o = 2'b00;
      if (last.vld && (!last.wen || WriteRespOn)) begin
         vld_o[last.owner] = 1'b1;
      end
   end

endmodule

// File: rtl/tcdm_bank_arb.sv
// Two-port arbiter in front of one TCDM bank with starvation escalation.
// Optional statistics counters: define TCDM_BANK_ARB_STATS_EN.
module tcdm_bank_arb
   import tcdm_interconnect_pkg::*;
#(
   parameter int AddrMemWidth = 12,
   parameter int DataWidth    = 32,
   parameter int BeWidth      = DataWidth / 8,
   parameter int RespLat      = 1,
   parameter bit WriteRespOn  = 1'b1,
   parameter int MaxStall     = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [1:0]                mode_i,
   input  logic [1:0]                req_i,
   input  logic [2*AddrMemWidth-1:0] add_i,
   input  logic [1:0]                wen_i,
   input  logic [2*DataWidth-1:0]    wdata_i,
   input  logic [2*BeWidth-1:0]      be_i,
   output logic [1:0]                gnt_o,
   output logic [1:0]                vld_o,
   output logic [2*DataWidth-1:0]    rdata_o,
   output logic                      bank_req_o,
   input  logic                      bank_gnt_i,
   output logic [AddrMemWidth-1:0]   bank_add_o,
   output logic                      bank_wen_o,
   output logic [DataWidth-1:0]      bank_wdata_o,
   output logic [BeWidth-1:0]        bank_be_o,
   input  logic [DataWidth-1:0]      bank_rdata_i,
   output logic [31:0]               stat_conflict_o,
   output logic [31:0]               stat_escal_o
);

   if (RespLat < 1) begin : g_bad_lat
      $error("tcdm_bank_arb: RespLat must be >= 1");
   end
   if (MaxStall < 1) begin : g_bad_stall
      $error("tcdm_bank_arb: MaxStall must be >= 1");
   end

   localparam int SW = $clog2(MaxStall + 1);
   typedef logic [SW-1:0] stall_t;
   localparam stall_t SMax = stall_t'(MaxStall);

   stall_t     stall0_q;
   stall_t     stall1_q;
   logic       rr_q;
   logic       conflict;
   logic       win;
   logic [1:0] esc;
   resp_tag_t  tag;

   function automatic stall_t stall_next(
      logic r, logic g, logic bg, stall_t s
   );
      if (!r || g) return '0;
      if (bg && s != SMax) return s + stall_t'(1);
      return s;
   endfunction

   assign esc      = {stall1_q == SMax, stall0_q == SMax};
   assign conflict = &req_i;

   // Escalation overrides the mode; with both starved, ext wins.
   always_comb begin
      win = 1'b0;
      if (!conflict) begin
         win = req_i[1];
      end else if (esc[1]) begin
         win = 1'b1;
      end else if (esc[0]) begin
         win = 1'b0;
      end else begin
         case (mode_i)
            ROUND_ROBIN: win = rr_q;
            EXT_PRIO:    win = 1'b1;
            default:     win = 1'b0;
         endcase
      end
   end

   always_comb begin
      gnt_o = 2'b00;
      if (bank_gnt_i && |req_i) begin
         gnt_o[win] = 1'b1;
      end
   end

   assign bank_req_o   = |req_i;
   assign bank_add_o   = win ? add_i[2*AddrMemWidth-1:AddrMemWidth]
                             : add_i[AddrMemWidth-1:0];
   assign bank_wen_o   = win ? wen_i[1] : wen_i[0];
   assign bank_wdata_o = win ? wdata_i[2*DataWidth-1:DataWidth]
                             : wdata_i[DataWidth-1:0];
   assign bank_be_o    = win ? be_i[2*BeWidth-1:BeWidth]
                             : be_i[BeWidth-1:0];
   assign rdata_o      = {2{bank_rdata_i}};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall0_q <= '0;
         stall1_q <= '0;
         rr_q     <= 1'b0;
      end else begin
         stall0_q <= stall_next(req_i[0], gnt_o[0], bank_gnt_i, stall0_q);
         stall1_q <= stall_next(req_i[1], gnt_o[1], bank_gnt_i, stall1_q);
         if (mode_i == ROUND_ROBIN && conflict && bank_gnt_i) begin
            rr_q <= ~win;
         end
      end
   end

   assign tag = '{vld: |gnt_o, owner: win, wen: bank_wen_o};

   tcdm_bank_resp_pipe #(
      .RespLat     (RespLat),
      .WriteRespOn (WriteRespOn)
   ) u_resp_pipe (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .tag_i (tag),
      .vld_o (vld_o)
   );

`ifdef TCDM_BANK_ARB_STATS_EN
   logic [31:0] conf_q;
   logic [31:0] escal_q;
   logic        escal_evt;

   assign escal_evt = |(gnt_o & esc);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         conf_q  <= '0;
         escal_q <= '0;
      end else begin
         if (conflict && conf_q != '1) conf_q <= conf_q + 32'd1;
         if (escal_evt && escal_q != '1) escal_q <= escal_q + 32'd1;
      end
   end

   assign stat_conflict_o = conf_q;
   assign stat_escal_o    = escal_q;
`else
   assign stat_conflict_o = '0;
   assign stat_escal_o    = '0;
`endif

endmodule

// File: tb/tb_tcdm_bank_arb.sv
// Directed bench for tcdm_bank_arb: two instances (RespLat 3 reads-only
// responses, RespLat 2 with write responses) share one set of inputs.
module tb_tcdm_bank_arb;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int BW = 4;

`ifdef TCDM_BANK_ARB_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    mode;
   logic [1:0]    req;
   logic [2*AW-1:0] add;
   logic [1:0]    wen;
   logic [2*DW-1:0] wdata;
   logic [2*BW-1:0] be;
   logic          bank_gnt;
   logic [DW-1:0] bank_rdata;

   logic [1:0]    a_gnt, a_vld, b_gnt, b_vld;
   logic [2*DW-1:0] a_rdata, b_rdata;
   logic          a_req, b_req, a_wen, b_wen;
   logic [AW-1:0] a_add, b_add;
   logic [DW-1:0] a_wdata, b_wdata;
   logic [BW-1:0] a_be, b_be;
   logic [31:0]   a_conf, a_escal, b_conf, b_escal;

   always #5 clk = ~clk;

   tcdm_bank_arb #(
      .AddrMemWidth(AW), .DataWidth(DW), .BeWidth(BW),
      .RespLat(3), .WriteRespOn(1'b0), .MaxStall(8)
   ) u_a (
      .clk_i(clk), .rst_i(rst), .mode_i(mode), .req_i(req),
      .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be),
      .gnt_o(a_gnt), .vld_o(a_vld), .rdata_o(a_rdata),
      .bank_req_o(a_req), .bank_gnt_i(bank_gnt),
      .bank_add_o(a_add), .bank_wen_o(a_wen),
      .bank_wdata_o(a_wdata), .bank_be_o(a_be),
      .bank_rdata_i(bank_rdata),
      .stat_conflict_o(a_conf), .stat_escal_o(a_escal)
   );

   tcdm_bank_arb #(
      .AddrMemWidth(AW), .DataWidth(DW), .BeWidth(BW),
      .RespLat(2), .WriteRespOn(1'b1), .MaxStall(8)
   ) u_b (
      .clk_i(clk), .rst_i(rst), .mode_i(mode), .req_i(req),
      .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be),
      .gnt_o(b_gnt), .vld_o(b_vld), .rdata_o(b_rdata),
      .bank_req_o(b_req), .bank_gnt_i(bank_gnt),
      .bank_add_o(b_add), .bank_wen_o(b_wen),
      .bank_wdata_o(b_wdata), .bank_be_o(b_be),
      .bank_rdata_i(bank_rdata),
      .stat_conflict_o(b_conf), .stat_escal_o(b_escal)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 2'b00;
      wen = 2'b00;
      bank_gnt = 1'b1;
      mode = 2'd0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic [1:0]  req;
      logic        bg;
      logic [1:0]  gnt;
      logic [11:0] add;
   } vec_t;

   vec_t tbl [14];

   initial begin
      tbl[0]  = '{2'd0, 2'b00, 1'b1, 2'b00, 12'h100};
      tbl[1]  = '{2'd0, 2'b01, 1'b1, 2'b01, 12'h100};
      tbl[2]  = '{2'd0, 2'b10, 1'b1, 2'b10, 12'h200};
      tbl[3]  = '{2'd0, 2'b11, 1'b1, 2'b01, 12'h100};
      tbl[4]  = '{2'd2, 2'b11, 1'b1, 2'b10, 12'h200};
      tbl[5]  = '{2'd3, 2'b11, 1'b1, 2'b01, 12'h100};
      tbl[6]  = '{2'd1, 2'b11, 1'b1, 2'b01, 12'h100};
      tbl[7]  = '{2'd1, 2'b11, 1'b1, 2'b10, 12'h200};
      tbl[8]  = '{2'd1, 2'b01, 1'b1, 2'b01, 12'h100};
      tbl[9]  = '{2'd1, 2'b11, 1'b0, 2'b00, 12'h100};
      tbl[10] = '{2'd1, 2'b11, 1'b1, 2'b01, 12'h100};
      tbl[11] = '{2'd0, 2'b10, 1'b1, 2'b10, 12'h200};
      tbl[12] = '{2'd1, 2'b11, 1'b1, 2'b10, 12'h200};
      tbl[13] = '{2'd2, 2'b00, 1'b1, 2'b00, 12'h100};

      add = {12'h200, 12'h100};
      wdata = {32'hBBBB1111, 32'hAAAA0000};
      be = {4'hC, 4'h3};
      bank_rdata = '0;

      // reset state
      do_reset();
      @(negedge clk);
      check("rst gnt", {a_gnt, b_gnt}, 4'b0);
      check("rst vld", {a_vld, b_vld}, 4'b0);
      check("rst bank_req", {a_req, b_req}, 2'b0);
      check("rst stats", {a_conf, a_escal}, 64'd0);
      tick();

      // per-cycle arbitration table
      for (int i = 0; i < 14; i++) begin
         mode = tbl[i].mode;
         req = tbl[i].req;
         bank_gnt = tbl[i].bg;
         @(negedge clk);
         check($sformatf("tbl%0d gnt_a", i), a_gnt, tbl[i].gnt);
         check($sformatf("tbl%0d gnt_b", i), b_gnt, tbl[i].gnt);
         check($sformatf("tbl%0d add", i), a_add, tbl[i].add);
         check($sformatf("tbl%0d bank_req", i), a_req, |tbl[i].req);
         tick();
      end

      // reset while a read is in flight
      do_reset();
      req = 2'b01;
      @(negedge clk);
      check("midrst gnt", a_gnt, 2'b01);
      tick();
      req = 2'b00;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("midrst vld %0d", k), {a_vld, b_vld}, 4'b0);
         check($sformatf("midrst out %0d", k), {a_gnt, a_req}, 3'b0);
         tick();
      end

      // core priority starvation escalation
      do_reset();
      mode = 2'd0;
      req = 2'b11;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("esc gnt %0d", i), a_gnt,
               (i == 8) ? 2'b10 : 2'b01);
         check($sformatf("esc gnt_b %0d", i), b_gnt,
               (i == 8) ? 2'b10 : 2'b01);
         tick();
      end
      req = 2'b00;
      @(negedge clk);
      check("esc stat_escal", a_escal, (STATS != 0) ? 32'd1 : 32'd0);
      check("esc stat_conf", a_conf, (STATS != 0) ? 32'd10 : 32'd0);
      tick();

      // round robin alternation
      do_reset();
      mode = 2'd1;
      req = 2'b11;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("rr gnt %0d", i), a_gnt,
               (i % 2 == 1) ? 2'b10 : 2'b01);
         tick();
      end
      req = 2'b00;
      @(negedge clk);
      check("rr stat_escal", b_escal, 32'd0);
      check("rr stat_conf", b_conf, (STATS != 0) ? 32'd6 : 32'd0);
      tick();

      // read latency 3 on port 1
      do_reset();
      add = {12'h005, 12'h100};
      req = 2'b10;
      @(negedge clk);
      check("lat gnt", a_gnt, 2'b10);
      check("lat add", a_add, 12'h005);
      check("lat wdata", a_wdata, 32'hBBBB1111);
      check("lat be", a_be, 4'hC);
      tick();
      req = 2'b00;
      @(negedge clk);
      check("lat t1 vld", {a_vld, b_vld}, 4'b0);
      tick();
      @(negedge clk);
      check("lat t2 vld_a", a_vld, 2'b00);
      check("lat t2 vld_b", b_vld, 2'b10);
      tick();
      bank_rdata = 32'hCAFE0005;
      @(negedge clk);
      check("lat t3 vld_a", a_vld, 2'b10);
      check("lat t3 rdata1", a_rdata[63:32], 32'hCAFE0005);
      check("lat t3 rdata_b", b_rdata, {2{32'hCAFE0005}});
      tick();
      @(negedge clk);
      check("lat t4 vld_a", a_vld, 2'b00);
      tick();
      add = {12'h200, 12'h100};

      // store responses depend on WriteRespOn
      do_reset();
      req = 2'b01;
      wen = 2'b01;
      @(negedge clk);
      check("wr gnt", a_gnt, 2'b01);
      check("wr bank_wen", a_wen, 1'b1);
      tick();
      req = 2'b00;
      wen = 2'b00;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check($sformatf("wr vld_a t%0d", k), a_vld, 2'b00);
         check($sformatf("wr vld_b t%0d", k), b_vld,
               (k == 2) ? 2'b01 : 2'b00);
         tick();
      end

      // back-to-back reads, no bubbles
      do_reset();
      req = 2'b01;
      tick();
      req = 2'b10;
      tick();
      req = 2'b00;
      @(negedge clk);
      check("b2b t2 vld_b", b_vld, 2'b01);
      check("b2b t2 vld_a", a_vld, 2'b00);
      tick();
      @(negedge clk);
      check("b2b t3 vld_b", b_vld, 2'b10);
      check("b2b t3 vld_a", a_vld, 2'b01);
      tick();
      @(negedge clk);
      check("b2b t4 vld_b", b_vld, 2'b00);
      check("b2b t4 vld_a", a_vld, 2'b10);
      tick();

      // bank stall freezes starvation counters
      do_reset();
      mode = 2'd0;
      req = 2'b11;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("bs pre %0d", i), a_gnt, 2'b01);
         tick();
      end
      bank_gnt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("bs hold gnt %0d", i), {a_gnt, b_gnt}, 4'b0);
         check($sformatf("bs hold req %0d", i), a_req, 1'b1);
         tick();
      end
      bank_gnt = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("bs post %0d", i), a_gnt,
               (i == 5) ? 2'b10 : 2'b01);
         tick();
      end
      req = 2'b00;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
